uart_tx_fifo_reader: RTL and testbench



---
 rtl/uart_tx_fifo_reader.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from the TX FIFO and sends start, data (LSB first), optional parity and stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bits.
module uart_tx_fifo_reader #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic              bit_done;
    logic [IDX_W-1:0]  idx_next;

    assign bit_done = (cnt_q == CNT_LAST);
    assign idx_next = idx_q + IDX_W'(1);

    // The bit index is shared: it walks the data bits and then counts the stop bits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop_d    = 1'b0;
        busy_d   = busy_q;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (!fifo_empty) begin
                    shift_d = fifo_data;
                    pop_d   = 1'b1;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_next;
                        tx_d  = shift_q[idx_next];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign fifo_pop = pop_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Testbench for uart_tx_fifo_reader: two instances (one and two stop bits) fed from queue FIFOs, compared every cycle
// against a frame-timeline reference model. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo_reader;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          fifoEmpty [2];
    logic [DW-1:0] fifoData  [2];
    logic          pop0, pop1, tx0, tx1, busy0, busy1;

    logic [DW-1:0] envQ   [2][$];
    logic [DW-1:0] modelQ [2][$];
    int            mK     [2];
    logic [DW-1:0] mByte  [2];
    int            popCount [2];
    int            pushCount = 0;

    int testsRun    = 0;
    int testsFailed = 0;

    uart_tx_fifo_reader #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dutStop1 (
        .clk(clk), .rst(rst), .fifo_empty(fifoEmpty[0]), .fifo_data(fifoData[0]),
        .fifo_pop(pop0), .tx(tx0), .busy(busy0)
    );

    uart_tx_fifo_reader #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dutStop2 (
        .clk(clk), .rst(rst), .fifo_empty(fifoEmpty[1]), .fifo_data(fifoData[1]),
        .fifo_pop(pop1), .tx(tx1), .busy(busy1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level of bit position idx within a frame carrying byte b.
    function automatic logic frameBit(input logic [DW-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return b[idx-1];
        if (PAR == 1 && idx == DW + 1) return ^b;
        return 1'b1;
    endfunction

    function automatic int lineLen(input int g);
        return (1 + DW + PAR + (g + 1)) * CPB;
    endfunction

    function automatic void refreshFifo(input int g);
        fifoEmpty[g] = (envQ[g].size() == 0);
        fifoData[g]  = fifoEmpty[g] ? DW'($urandom) : envQ[g][0];
    endfunction

    // One clock: advance the model on the rising edge, compare and service pops on the falling edge.
    task automatic tick();
        logic obsTx, obsBusy, obsPop;
        @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                mK[g] = -1;
            end else if (mK[g] >= 0) begin
                mK[g]++;
                if (mK[g] == lineLen(g)) mK[g] = -1;
            end else if (!fifoEmpty[g]) begin
                mByte[g] = (modelQ[g].size() > 0) ? modelQ[g].pop_front() : '0;
                mK[g]    = 0;
            end
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            obsTx   = (g == 0) ? tx0   : tx1;
            obsBusy = (g == 0) ? busy0 : busy1;
            obsPop  = (g == 0) ? pop0  : pop1;
            checkOutput($sformatf("tx stop%0d", g + 1), 32'(obsTx),
                        32'((mK[g] < 0) ? 1'b1 : frameBit(mByte[g], mK[g] / CPB)));
            checkOutput($sformatf("busy stop%0d", g + 1), 32'(obsBusy), 32'(mK[g] >= 0));
            checkOutput($sformatf("fifo_pop stop%0d", g + 1), 32'(obsPop), 32'(mK[g] == 0));
            if (obsPop === 1'b1) begin
                popCount[g]++;
                if (envQ[g].size() > 0) void'(envQ[g].pop_front());
            end
            refreshFifo(g);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] b);
        for (int g = 0; g < 2; g++) begin
            envQ[g].push_back(b);
            modelQ[g].push_back(b);
            refreshFifo(g);
        end
        pushCount++;
    endtask

    task automatic waitDrained(input int budget);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (mK[0] < 0) && (mK[1] < 0) && fifoEmpty[0] && fifoEmpty[1];
        end
        checkOutput("drain timeout", 32'(done), 32'd1);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            mK[g]       = -1;
            mByte[g]    = '0;
            popCount[g] = 0;
            refreshFifo(g);
        end

        // Reset, then a long idle stretch with nothing queued.
        repeat (3) tick();
        rst = 1'b0;
        repeat (100) tick();

        // Single frame.
        applyStimulus(8'hA5);
        waitDrained(200);

        // Two frames queued together go out back to back.
        applyStimulus(8'h55);
        applyStimulus(8'h0F);
        waitDrained(300);

        applyStimulus(8'h07);
        applyStimulus(8'h00);
        waitDrained(300);

        // Reset in the middle of data bit 3, with another byte still waiting.
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        repeat (18) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        waitDrained(300);

        // Random bytes at random spacing, with occasional short resets.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(DW'($urandom));
            if ($urandom_range(0, 3) == 0) applyStimulus(DW'($urandom));
            repeat ($urandom_range(0, 70)) tick();
            if ($urandom_range(0, 12) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end
        end
        waitDrained(8000);
        repeat (10) tick();

        checkOutput("pop count stop1", 32'(popCount[0]), 32'(pushCount));
        checkOutput("pop count stop2", 32'(popCount[1]), 32'(pushCount));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
